// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bus: push strobe/data in, head entry out, pop strobe in.
// Latency: wires only, no storage.
// Backpressure: IQ_is_full warns fetch one slot early; IQ_enable pops the presented head.
interface inst_queue_if #(
  parameter int INST_W = 32,
  parameter int ADDR_W = 32
);
  logic              IF_inst_valid;
  logic [INST_W-1:0] IF_inst;
  logic [ADDR_W-1:0] IF_pc;
  logic              IQ_is_full;
  logic              IQ_inst_valid;
  logic [INST_W-1:0] IQ_inst;
  logic [ADDR_W-1:0] IQ_pc;
  logic              IQ_enable;

  // Fetch/decoder side: drives pushes and pops, observes the head.
  modport master (
    output IF_inst_valid, IF_inst, IF_pc, IQ_enable,
    input  IQ_is_full, IQ_inst_valid, IQ_inst, IQ_pc
  );

  // Queue side.
  modport slave (
    input  IF_inst_valid, IF_inst, IF_pc, IQ_enable,
    output IQ_is_full, IQ_inst_valid, IQ_inst, IQ_pc
  );
endinterface

// File: rtl/inst_queue.sv
// Circular FIFO of fetched instructions between fetch (push) and decoder (pop), flushable on mispredict.
// Latency: push visible at head 1 cycle later; head is presented combinationally from registered state.
// Backpressure: IQ_is_full at DEPTH-1 entries; push at DEPTH without a same-cycle pop is dropped; rdy=0 freezes.
module inst_queue #(
  parameter int DEPTH_LOG2 = 4,
  parameter int INST_W     = 32,
  parameter int ADDR_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  inst_queue_if.slave iq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] C_DEPTH     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_NEAR_FULL = CNT_W'(DEPTH - 1);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t                r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  logic [CNT_W-1:0]      r_count;

  logic   w_nonempty;
  logic   w_pop;
  logic   w_push;
  logic   w_adv;
  entry_t w_head_ent;

  assign w_nonempty = (r_count != '0);
  // A pop on an empty queue is ignored.
  assign w_pop      = iq.IQ_enable && w_nonempty;
  // At full, a push is only accepted if the head leaves in the same cycle.
  assign w_push     = iq.IF_inst_valid && ((r_count < C_DEPTH) || w_pop);
  // State only moves when globally ready and not being flushed.
  assign w_adv      = rdy && !clear;
  assign w_head_ent = r_mem[r_head];

  assign iq.IQ_inst_valid = w_nonempty;
  assign iq.IQ_inst       = w_nonempty ? w_head_ent.inst : '0;
  assign iq.IQ_pc         = w_nonempty ? w_head_ent.pc   : '0;
  // One slot of slack absorbs the push fetch has already registered.
  assign iq.IQ_is_full    = (r_count >= C_NEAR_FULL);

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (w_adv && w_push) begin
      r_mem[r_tail] <= {iq.IF_inst, iq.IF_pc};
    end
  end

  // Pointer and occupancy update: freeze, then flush, then push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy) begin
      if (clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_tail <= r_tail + DEPTH_LOG2'(1);
        end
        if (w_pop) begin
          r_head <= r_head + DEPTH_LOG2'(1);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
